wb_port_arbiter: RTL and testbench

- Shares the single register-file write port between two requesters:
  - the in-order pipeline writeback, i.e. the already-muxed wD from the WB stage;
  - a long-latency unit (multiplier/divider) that returns results out of band.
- Long-unit results are queued in a small buffer and written in idle WB slots.
- A starvation counter forces a one-cycle pipeline stall so the buffer drains.
- Sits between the WB stage and the register file. Also exports pending-rd hits to the hazard unit.

---
 rtl/wb_port_arbiter.sv | 195 +++++++++++++++++++
 tb/tb_wb_port_arbiter.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_port_arbiter.sv
// -----------------------------------------------------------------------------
// wb_port_arbiter
//
// Purpose:
//   Shares the single register-file write port between the in-order pipeline
//   writeback (already-muxed WB data) and a long-latency unit (mul/div) that
//   returns results out of band. Long-unit results that cannot be written
//   immediately are queued in a small circular buffer and drained in idle WB
//   slots. If the buffer keeps losing arbitration, a one-cycle pipeline stall
//   is forced so one entry can drain. Pending destination registers in the
//   buffer are reported to the hazard unit.
//
// Ports:
//   clk, rst_n                         clock, synchronous active-low reset
//   pipe_we_wb, pipe_wr_wb, pipe_wD    WB stage write request
//   lu_valid, lu_rd, lu_data, lu_ready long-unit result handshake
//   rs1_id, rs2_id                     ID-stage source registers (hazard query)
//   rf_we, rf_wr, rf_wD                register-file write port
//   pipe_stall                         one-cycle freeze during forced drain
//   pend_hit1, pend_hit2               source matches a live buffered entry
// -----------------------------------------------------------------------------
module wb_port_arbiter #(
    parameter int DEPTH      = 2,
    parameter int STARVE_MAX = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        pipe_we_wb,
    input  logic [4:0]  pipe_wr_wb,
    input  logic [31:0] pipe_wD,
    input  logic        lu_valid,
    input  logic [4:0]  lu_rd,
    input  logic [31:0] lu_data,
    output logic        lu_ready,
    input  logic [4:0]  rs1_id,
    input  logic [4:0]  rs2_id,
    output logic        rf_we,
    output logic [4:0]  rf_wr,
    output logic [31:0] rf_wD,
    output logic        pipe_stall,
    output logic        pend_hit1,
    output logic        pend_hit2
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam int STV_W = $clog2(STARVE_MAX + 1);
    localparam logic [CNT_W-1:0] FULL_CNT   = CNT_W'(DEPTH);
    localparam logic [STV_W-1:0] STARVE_LIM = STV_W'(STARVE_MAX);

    // Buffer storage. Only the live bits are reset; rd/data are don't-care
    // whenever the corresponding live bit is clear.
    logic        live_q [DEPTH];
    logic        live_d [DEPTH];
    logic [4:0]  rd_q   [DEPTH];
    logic [4:0]  rd_d   [DEPTH];
    logic [31:0] data_q [DEPTH];
    logic [31:0] data_d [DEPTH];

    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [STV_W-1:0] starve_q, starve_d;
    logic             drain_q, drain_d;

    logic empty;
    logic pipe_grant;
    logic pop;
    logic bypass;
    logic push;

    // Arbitration and port outputs
    always_comb begin
        empty      = (count_q == '0);
        lu_ready   = (count_q != FULL_CNT);
        pipe_grant = 1'b0;
        pop        = 1'b0;
        bypass     = 1'b0;
        rf_we      = 1'b0;
        rf_wr      = '0;
        rf_wD      = '0;
        pipe_stall = 1'b0;

        if (drain_q) begin
            // Forced drain: WB is frozen and retries its write next cycle.
            pipe_stall = 1'b1;
            pop        = !empty;
            rf_we      = !empty && live_q[head_q];
            if (rf_we) begin
                rf_wr = rd_q[head_q];
                rf_wD = data_q[head_q];
            end
        end else if (pipe_we_wb && (pipe_wr_wb != 5'd0)) begin
            pipe_grant = 1'b1;
            rf_we      = 1'b1;
            rf_wr      = pipe_wr_wb;
            rf_wD      = pipe_wD;
        end else if (!empty) begin
            // A dead head still consumes this slot, just without a write.
            pop   = 1'b1;
            rf_we = live_q[head_q];
            if (rf_we) begin
                rf_wr = rd_q[head_q];
                rf_wD = data_q[head_q];
            end
        end else if (lu_valid && (lu_rd != 5'd0)) begin
            bypass = 1'b1;
            rf_we  = 1'b1;
            rf_wr  = lu_rd;
            rf_wD  = lu_data;
        end

        // x0 results are acknowledged but never stored.
        push = lu_valid && lu_ready && (lu_rd != 5'd0) && !bypass;
    end

    // Buffer, pointer and starvation next-state
    always_comb begin
        live_d = live_q;
        rd_d   = rd_q;
        data_d = data_q;

        // A granted pipeline write is younger than anything buffered, so any
        // buffered result for the same register is now obsolete.
        if (pipe_grant) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (rd_q[i] == pipe_wr_wb) begin
                    live_d[i] = 1'b0;
                end
            end
        end

        if (pop) begin
            live_d[head_q] = 1'b0;
        end

        if (push) begin
            live_d[tail_q] = !(pipe_grant && (lu_rd == pipe_wr_wb));
            rd_d[tail_q]   = lu_rd;
            data_d[tail_q] = lu_data;
        end

        head_d  = head_q + PTR_W'(pop);
        tail_d  = tail_q + PTR_W'(push);
        count_d = count_q + CNT_W'(push) - CNT_W'(pop);

        if (drain_q || pop || empty) begin
            starve_d = '0;
        end else if (pipe_grant) begin
            starve_d = starve_q + 1'b1;
        end else begin
            starve_d = starve_q;
        end

        drain_d = !drain_q && (starve_d == STARVE_LIM);
    end

    // Hazard query over registered live entries only
    always_comb begin
        pend_hit1 = 1'b0;
        pend_hit2 = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (live_q[i] && (rd_q[i] == rs1_id)) pend_hit1 = 1'b1;
            if (live_q[i] && (rd_q[i] == rs2_id)) pend_hit2 = 1'b1;
        end
        if (rs1_id == 5'd0) pend_hit1 = 1'b0;
        if (rs2_id == 5'd0) pend_hit2 = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                live_q[i] <= 1'b0;
            end
            head_q   <= '0;
            tail_q   <= '0;
            count_q  <= '0;
            starve_q <= '0;
            drain_q  <= 1'b0;
        end else begin
            live_q   <= live_d;
            head_q   <= head_d;
            tail_q   <= tail_d;
            count_q  <= count_d;
            starve_q <= starve_d;
            drain_q  <= drain_d;
        end
    end

    always_ff @(posedge clk) begin
        rd_q   <= rd_d;
        data_q <= data_d;
    end

endmodule

// File: tb/tb_wb_port_arbiter.sv
module tb_wb_port_arbiter;

    logic        clk;
    logic        rst_n;
    logic        pipe_we_wb;
    logic [4:0]  pipe_wr_wb;
    logic [31:0] pipe_wD;
    logic        lu_valid;
    logic [4:0]  lu_rd;
    logic [31:0] lu_data;
    logic        lu_ready;
    logic [4:0]  rs1_id;
    logic [4:0]  rs2_id;
    logic        rf_we;
    logic [4:0]  rf_wr;
    logic [31:0] rf_wD;
    logic        pipe_stall;
    logic        pend_hit1;
    logic        pend_hit2;

    int vectors     = 0;
    int miscompares = 0;

    wb_port_arbiter #(.DEPTH(2), .STARVE_MAX(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .pipe_we_wb (pipe_we_wb),
        .pipe_wr_wb (pipe_wr_wb),
        .pipe_wD    (pipe_wD),
        .lu_valid   (lu_valid),
        .lu_rd      (lu_rd),
        .lu_data    (lu_data),
        .lu_ready   (lu_ready),
        .rs1_id     (rs1_id),
        .rs2_id     (rs2_id),
        .rf_we      (rf_we),
        .rf_wr      (rf_wr),
        .rf_wD      (rf_wD),
        .pipe_stall (pipe_stall),
        .pend_hit1  (pend_hit1),
        .pend_hit2  (pend_hit2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One cycle of stimulus plus the outputs required during that cycle.
    typedef struct packed {
        logic        rst_n;
        logic        pwe;
        logic [4:0]  pwr;
        logic [31:0] pwd;
        logic        lv;
        logic [4:0]  lrd;
        logic [31:0] ldat;
        logic [4:0]  r1;
        logic [4:0]  r2;
        logic        ewe;
        logic [4:0]  ewr;
        logic [31:0] ewd;
        logic        est;
        logic        erdy;
        logic        eh1;
        logic        eh2;
    } vec_t;

    vec_t exp_q[$];

    // Drive one cycle of stimulus after the falling edge and queue its
    // expectation; outputs settle well before the next rising edge.
    task automatic apply(input vec_t v);
        @(negedge clk);
        rst_n      = v.rst_n;
        pipe_we_wb = v.pwe;
        pipe_wr_wb = v.pwr;
        pipe_wD    = v.pwd;
        lu_valid   = v.lv;
        lu_rd      = v.lrd;
        lu_data    = v.ldat;
        rs1_id     = v.r1;
        rs2_id     = v.r2;
        exp_q.push_back(v);
        #2;
    endtask

    localparam logic [31:0] Z32 = 32'h0;

    task automatic test_reset();
        vec_t v[$];
        vec_t e;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        //                rst   pwe   pwr    pwd            lv    lrd    ldat  r1     r2     we    wr     wD             st    rdy   h1    h2
        v.push_back('{1'b0, 1'b0, 5'd0,  Z32,           1'b0, 5'd0,  Z32,  5'd0,  5'd0,  1'b0, 5'd0,  Z32,           1'b0, 1'b1, 1'b0, 1'b0});
        v.push_back('{1'b1, 1'b1, 5'd5,  32'hDEADBEEF,  1'b0, 5'd0,  Z32,  5'd0,  5'd0,  1'b1, 5'd5,  32'hDEADBEEF,  1'b0, 1'b1, 1'b0, 1'b0});
        v.push_back('{1'b1, 1'b1, 5'd0,  32'h1234,      1'b0, 5'd0,  Z32,  5'd0,  5'd0,  1'b0, 5'd0,  Z32,           1'b0, 1'b1, 1'b0, 1'b0});
        v.push_back('{1'b1, 1'b0, 5'd0,  Z32,           1'b0, 5'd0,  Z32,  5'd5,  5'd5,  1'b0, 5'd0,  Z32,           1'b0, 1'b1, 1'b0, 1'b0});
        foreach (v[i]) begin
            apply(v[i]);
            e = exp_q.pop_front();
            vectors++;
            if ({rf_we, rf_wr, rf_wD, pipe_stall, lu_ready, pend_hit1, pend_hit2} !==
                {e.ewe, e.ewr, e.ewd, e.est, e.erdy, e.eh1, e.eh2}) begin
                miscompares++;
                $display("FAIL reset[%0d]: got we=%b wr=%0d wD=%h stall=%b rdy=%b h1=%b h2=%b, want we=%b wr=%0d wD=%h stall=%b rdy=%b h1=%b h2=%b",
                         i, rf_we, rf_wr, rf_wD, pipe_stall, lu_ready, pend_hit1, pend_hit2,
                         e.ewe, e.ewr, e.ewd, e.est, e.erdy, e.eh1, e.eh2);
            end
        end
    endtask

    task automatic test_bypass();
        vec_t v[$];
        vec_t e;
        v.push_back('{1'b1, 1'b0, 5'd0,  Z32,  1'b1, 5'd7,  32'h12, 5'd7,  5'd7,  1'b1, 5'd7,  32'h12, 1'b0, 1'b1, 1'b0, 1'b0});
        v.push_back('{1'b1, 1'b0, 5'd0,  Z32,  1'b0, 5'd0,  Z32,    5'd7,  5'd0,  1'b0, 5'd0,  Z32,    1'b0, 1'b1, 1'b0, 1'b0});
        v.push_back('{1'b1, 1'b0, 5'd0,  Z32,  1'b1, 5'd0,  32'h55, 5'd0,  5'd0,  1'b0, 5'd0,  Z32,    1'b0, 1'b1, 1'b0, 1'b0});
        v.push_back('{1'b1, 1'b0, 5'd0,  Z32,  1'b0, 5'd0,  Z32,    5'd0,  5'd0,  1'b0, 5'd0,  Z32,    1'b0, 1'b1, 1'b0, 1'b0});
        foreach (v[i]) begin
            apply(v[i]);
            e = exp_q.pop_front();
            vectors++;
            if ({rf_we, rf_wr, rf_wD, pipe_stall, lu_ready, pend_hit1, pend_hit2} !==
                {e.ewe, e.ewr, e.ewd, e.est, e.erdy, e.eh1, e.eh2}) begin
                miscompares++;
                $display("FAIL bypass[%0d]: got we=%b wr=%0d wD=%h stall=%b rdy=%b h1=%b h2=%b, want we=%b wr=%0d wD=%h stall=%b rdy=%b h1=%b h2=%b",
                         i, rf_we, rf_wr, rf_wD, pipe_stall, lu_ready, pend_hit1, pend_hit2,
                         e.ewe, e.ewr, e.ewd, e.est, e.erdy, e.eh1, e.eh2);
            end
        end
    endtask

    task automatic test_fill();
        vec_t v[$];
        vec_t e;
        v.push_back('{1'b1, 1'b1, 5'd10, 32'hA1, 1'b1, 5'd3,  32'h33, 5'd0,  5'd0,  1'b1, 5'd10, 32'hA1, 1'b0, 1'b1, 1'b0, 1'b0});
        v.push_back('{1'b1, 1'b1, 5'd11, 32'hA2, 1'b1, 5'd4,  32'h44, 5'd0,  5'd0,  1'b1, 5'd11, 32'hA2, 1'b0, 1'b1, 1'b0, 1'b0});
        v.push_back('{1'b1, 1'b1, 5'd12, 32'hA3, 1'b0, 5'd0,  Z32,    5'd3,  5'd0,  1'b1, 5'd12, 32'hA3, 1'b0, 1'b0, 1'b1, 1'b0});
        v.push_back('{1'b1, 1'b0, 5'd0,  Z32,    1'b0, 5'd0,  Z32,    5'd4,  5'd3,  1'b1, 5'd3,  32'h33, 1'b0, 1'b0, 1'b1, 1'b1});
        v.push_back('{1'b1, 1'b0, 5'd0,  Z32,    1'b0, 5'd0,  Z32,    5'd4,  5'd3,  1'b1, 5'd4,  32'h44, 1'b0, 1'b1, 1'b1, 1'b0});
        v.push_back('{1'b1, 1'b0, 5'd0,  Z32,    1'b0, 5'd0,  Z32,    5'd0,  5'd0,  1'b0, 5'd0,  Z32,    1'b0, 1'b1, 1'b0, 1'b0});
        foreach (v[i]) begin
            apply(v[i]);
            e = exp_q.pop_front();
            vectors++;
            if ({rf_we, rf_wr, rf_wD, pipe_stall, lu_ready, pend_hit1, pend_hit2} !==
                {e.ewe, e.ewr, e.ewd, e.est, e.erdy, e.eh1, e.eh2}) begin
                miscompares++;
                $display("FAIL fill[%0d]: got we=%b wr=%0d wD=%h stall=%b rdy=%b h1=%b h2=%b, want we=%b wr=%0d wD=%h stall=%b rdy=%b h1=%b h2=%b",
                         i, rf_we, rf_wr, rf_wD, pipe_stall, lu_ready, pend_hit1, pend_hit2,
                         e.ewe, e.ewr, e.ewd, e.est, e.erdy, e.eh1, e.eh2);
            end
        end
    endtask

    task automatic test_starvation();
        vec_t v[$];
        vec_t e;
        v.push_back('{1'b1, 1'b1, 5'd20, 32'hB0, 1'b1, 5'd6,  32'h66, 5'd0,  5'd0,  1'b1, 5'd20, 32'hB0, 1'b0, 1'b1, 1'b0, 1'b0});
        v.push_back('{1'b1, 1'b1, 5'd21, 32'hB1, 1'b0, 5'd0,  Z32,    5'd6,  5'd0,  1'b1, 5'd21, 32'hB1, 1'b0, 1'b1, 1'b1, 1'b0});
        v.push_back('{1'b1, 1'b1, 5'd22, 32'hB2, 1'b0, 5'd0,  Z32,    5'd0,  5'd0,  1'b1, 5'd22, 32'hB2, 1'b0, 1'b1, 1'b0, 1'b0});
        v.push_back('{1'b1, 1'b1, 5'd23, 32'hB3, 1'b0, 5'd0,  Z32,    5'd0,  5'd0,  1'b1, 5'd23, 32'hB3, 1'b0, 1'b1, 1'b0, 1'b0});
        v.push_back('{1'b1, 1'b1, 5'd24, 32'hB4, 1'b0, 5'd0,  Z32,    5'd0,  5'd0,  1'b1, 5'd24, 32'hB4, 1'b0, 1'b1, 1'b0, 1'b0});
        // Forced drain: WB request is refused, buffered x6 is written.
        v.push_back('{1'b1, 1'b1, 5'd25, 32'hB5, 1'b0, 5'd0,  Z32,    5'd0,  5'd0,  1'b1, 5'd6,  32'h66, 1'b1, 1'b1, 1'b0, 1'b0});
        // WB held its request across the stall; it lands now.
        v.push_back('{1'b1, 1'b1, 5'd25, 32'hB5, 1'b0, 5'd0,  Z32,    5'd0,  5'd0,  1'b1, 5'd25, 32'hB5, 1'b0, 1'b1, 1'b0, 1'b0});
        v.push_back('{1'b1, 1'b0, 5'd0,  Z32,    1'b0, 5'd0,  Z32,    5'd0,  5'd0,  1'b0, 5'd0,  Z32,    1'b0, 1'b1, 1'b0, 1'b0});
        foreach (v[i]) begin
            apply(v[i]);
            e = exp_q.pop_front();
            vectors++;
            if ({rf_we, rf_wr, rf_wD, pipe_stall, lu_ready, pend_hit1, pend_hit2} !==
                {e.ewe, e.ewr, e.ewd, e.est, e.erdy, e.eh1, e.eh2}) begin
                miscompares++;
                $display("FAIL starve[%0d]: got we=%b wr=%0d wD=%h stall=%b rdy=%b h1=%b h2=%b, want we=%b wr=%0d wD=%h stall=%b rdy=%b h1=%b h2=%b",
                         i, rf_we, rf_wr, rf_wD, pipe_stall, lu_ready, pend_hit1, pend_hit2,
                         e.ewe, e.ewr, e.ewd, e.est, e.erdy, e.eh1, e.eh2);
            end
        end
    endtask

    task automatic test_waw();
        vec_t v[$];
        vec_t e;
        v.push_back('{1'b1, 1'b1, 5'd1,  32'h1,    1'b1, 5'd9,  32'hAAAA, 5'd0,  5'd0,  1'b1, 5'd1,  32'h1,    1'b0, 1'b1, 1'b0, 1'b0});
        v.push_back('{1'b1, 1'b1, 5'd9,  32'hBBBB, 1'b0, 5'd0,  Z32,      5'd9,  5'd0,  1'b1, 5'd9,  32'hBBBB, 1'b0, 1'b1, 1'b1, 1'b0});
        v.push_back('{1'b1, 1'b0, 5'd0,  Z32,      1'b0, 5'd0,  Z32,      5'd9,  5'd9,  1'b0, 5'd0,  Z32,      1'b0, 1'b1, 1'b0, 1'b0});
        // Same-cycle push and pipeline write to x8: stored dead.
        v.push_back('{1'b1, 1'b1, 5'd8,  32'hC8,   1'b1, 5'd8,  32'hDD,   5'd8,  5'd0,  1'b1, 5'd8,  32'hC8,   1'b0, 1'b1, 1'b0, 1'b0});
        v.push_back('{1'b1, 1'b0, 5'd0,  Z32,      1'b0, 5'd0,  Z32,      5'd8,  5'd8,  1'b0, 5'd0,  Z32,      1'b0, 1'b1, 1'b0, 1'b0});
        v.push_back('{1'b1, 1'b0, 5'd0,  Z32,      1'b0, 5'd0,  Z32,      5'd0,  5'd0,  1'b0, 5'd0,  Z32,      1'b0, 1'b1, 1'b0, 1'b0});
        foreach (v[i]) begin
            apply(v[i]);
            e = exp_q.pop_front();
            vectors++;
            if ({rf_we, rf_wr, rf_wD, pipe_stall, lu_ready, pend_hit1, pend_hit2} !==
                {e.ewe, e.ewr, e.ewd, e.est, e.erdy, e.eh1, e.eh2}) begin
                miscompares++;
                $display("FAIL waw[%0d]: got we=%b wr=%0d wD=%h stall=%b rdy=%b h1=%b h2=%b, want we=%b wr=%0d wD=%h stall=%b rdy=%b h1=%b h2=%b",
                         i, rf_we, rf_wr, rf_wD, pipe_stall, lu_ready, pend_hit1, pend_hit2,
                         e.ewe, e.ewr, e.ewd, e.est, e.erdy, e.eh1, e.eh2);
            end
        end
    endtask

    task automatic test_back_to_back();
        vec_t v[$];
        vec_t e;
        v.push_back('{1'b1, 1'b1, 5'd10, 32'hF0, 1'b1, 5'd17, 32'h71, 5'd0,  5'd0,  1'b1, 5'd10, 32'hF0, 1'b0, 1'b1, 1'b0, 1'b0});
        v.push_back('{1'b1, 1'b0, 5'd0,  Z32,    1'b1, 5'd18, 32'h81, 5'd17, 5'd0,  1'b1, 5'd17, 32'h71, 1'b0, 1'b1, 1'b1, 1'b0});
        v.push_back('{1'b1, 1'b0, 5'd0,  Z32,    1'b1, 5'd19, 32'h91, 5'd18, 5'd0,  1'b1, 5'd18, 32'h81, 1'b0, 1'b1, 1'b1, 1'b0});
        v.push_back('{1'b1, 1'b0, 5'd0,  Z32,    1'b0, 5'd0,  Z32,    5'd19, 5'd0,  1'b1, 5'd19, 32'h91, 1'b0, 1'b1, 1'b1, 1'b0});
        v.push_back('{1'b1, 1'b0, 5'd0,  Z32,    1'b0, 5'd0,  Z32,    5'd19, 5'd0,  1'b0, 5'd0,  Z32,    1'b0, 1'b1, 1'b0, 1'b0});
        foreach (v[i]) begin
            apply(v[i]);
            e = exp_q.pop_front();
            vectors++;
            if ({rf_we, rf_wr, rf_wD, pipe_stall, lu_ready, pend_hit1, pend_hit2} !==
                {e.ewe, e.ewr, e.ewd, e.est, e.erdy, e.eh1, e.eh2}) begin
                miscompares++;
                $display("FAIL b2b[%0d]: got we=%b wr=%0d wD=%h stall=%b rdy=%b h1=%b h2=%b, want we=%b wr=%0d wD=%h stall=%b rdy=%b h1=%b h2=%b",
                         i, rf_we, rf_wr, rf_wD, pipe_stall, lu_ready, pend_hit1, pend_hit2,
                         e.ewe, e.ewr, e.ewd, e.est, e.erdy, e.eh1, e.eh2);
            end
        end
    endtask

    task automatic test_reset_midqueue();
        vec_t v[$];
        vec_t e;
        v.push_back('{1'b1, 1'b1, 5'd2,  32'hE1, 1'b1, 5'd13, 32'hD1, 5'd0,  5'd0,  1'b1, 5'd2,  32'hE1, 1'b0, 1'b1, 1'b0, 1'b0});
        v.push_back('{1'b1, 1'b1, 5'd2,  32'hE2, 1'b1, 5'd14, 32'hD2, 5'd0,  5'd0,  1'b1, 5'd2,  32'hE2, 1'b0, 1'b1, 1'b0, 1'b0});
        v.push_back('{1'b0, 1'b1, 5'd2,  32'hE3, 1'b0, 5'd0,  Z32,    5'd13, 5'd0,  1'b1, 5'd2,  32'hE3, 1'b0, 1'b0, 1'b1, 1'b0});
        v.push_back('{1'b1, 1'b0, 5'd0,  Z32,    1'b0, 5'd0,  Z32,    5'd13, 5'd14, 1'b0, 5'd0,  Z32,    1'b0, 1'b1, 1'b0, 1'b0});
        v.push_back('{1'b1, 1'b0, 5'd0,  Z32,    1'b0, 5'd0,  Z32,    5'd0,  5'd0,  1'b0, 5'd0,  Z32,    1'b0, 1'b1, 1'b0, 1'b0});
        foreach (v[i]) begin
            apply(v[i]);
            e = exp_q.pop_front();
            vectors++;
            if ({rf_we, rf_wr, rf_wD, pipe_stall, lu_ready, pend_hit1, pend_hit2} !==
                {e.ewe, e.ewr, e.ewd, e.est, e.erdy, e.eh1, e.eh2}) begin
                miscompares++;
                $display("FAIL rst_mid[%0d]: got we=%b wr=%0d wD=%h stall=%b rdy=%b h1=%b h2=%b, want we=%b wr=%0d wD=%h stall=%b rdy=%b h1=%b h2=%b",
                         i, rf_we, rf_wr, rf_wD, pipe_stall, lu_ready, pend_hit1, pend_hit2,
                         e.ewe, e.ewr, e.ewd, e.est, e.erdy, e.eh1, e.eh2);
            end
        end
    endtask

    initial begin
        rst_n      = 1'b0;
        pipe_we_wb = 1'b0;
        pipe_wr_wb = 5'd0;
        pipe_wD    = 32'h0;
        lu_valid   = 1'b0;
        lu_rd      = 5'd0;
        lu_data    = 32'h0;
        rs1_id     = 5'd0;
        rs2_id     = 5'd0;

        test_reset();
        test_bypass();
        test_fill();
        test_starvation();
        test_waw();
        test_back_to_back();
        test_reset_midqueue();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
